toy_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between the RISC_TOY instruction-fetch port (I) and data port (D).
//  D has fixed priority; a starvation counter guarantees I a slot after MAX_DSTREAK back-to-back D grants.

---
 rtl/toy_mem_arbiter_pkg.sv | 23 ++
 rtl/toy_mem_arbiter_if.sv | 33 +++
 rtl/toy_mem_arbiter_starve_ctr.sv | 32 +++
 rtl/toy_mem_arbiter.sv | 119 +++++++++++
 tb/tb_toy_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/toy_mem_arbiter_pkg.sv
// Shared types and defaults for the RISC_TOY I/D memory arbiter.
// Holds the read-return tag, DRW encoding and default geometry.
package toy_mem_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    localparam logic DRW_READ  = 1'b0;
    localparam logic DRW_WRITE = 1'b1;

    localparam int DEF_AW          = 10;
    localparam int DEF_BW          = 32;
    localparam int DEF_MAX_DSTREAK = 4;

    // True when the word address lies beyond the 2**aw-entry SRAM.
    function automatic logic addr_oor(input logic [29:0] a, input int aw);
        return |(a >> aw);
    endfunction

endpackage

// File: rtl/toy_mem_arbiter_if.sv
// Core-side fetch/data request bundle of the memory arbiter.
// master = core, slave = arbiter.
interface toy_mem_arbiter_if #(
    parameter int BW = toy_mem_pkg::DEF_BW
);
    logic          i_req;
    logic [29:0]   i_addr;
    logic          i_gnt;
    logic          i_valid;
    logic [BW-1:0] i_rdata;

    logic          d_req;
    logic          d_rw;
    logic [29:0]   d_addr;
    logic [BW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_valid;
    logic [BW-1:0] d_rdata;

    modport master (
        output i_req, i_addr,
        output d_req, d_rw, d_addr, d_wdata,
        input  i_gnt, i_valid, i_rdata,
        input  d_gnt, d_valid, d_rdata
    );

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_rw, d_addr, d_wdata,
        output i_gnt, i_valid, i_rdata,
        output d_gnt, d_valid, d_rdata
    );
endinterface

// File: rtl/toy_mem_arbiter_starve_ctr.sv
// Counts back-to-back D grants while fetch waits.
// force_i hands the next slot to I once the streak limit is hit.
module toy_starve_ctr #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_gnt,
    input  logic i_req,
    output logic force_i
);
    logic [3:0] streak;
    logic [3:0] streak_nxt;

    always_comb begin
        streak_nxt = '0;
        if (i_req && d_gnt) begin
            streak_nxt = (streak == 4'hF) ? streak : streak + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else begin
            streak <= streak_nxt;
        end
    end

    assign force_i = (streak == 4'(MAX_DSTREAK));

endmodule

// File: rtl/toy_mem_arbiter.sv
// Single-port SRAM arbiter between RISC_TOY fetch (I) and data (D).
// D has priority; a streak limit guarantees I forward progress.
module toy_mem_arbiter
    import toy_mem_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int BW          = DEF_BW,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
    input  logic          clk,
    input  logic          rst,
    toy_mem_arbiter_if.slave bus,
    output logic          m_csn,
    output logic          m_wen,
    output logic [AW-1:0] m_a,
    output logic [BW-1:0] m_di,
    input  logic [BW-1:0] m_dout,
    output logic          addr_err
);
    logic          force_i;
    logic          d_win;
    logic          i_win;
    logic          i_oor;
    logic          d_oor;
    logic          win_oor;
    logic          oor_q;
    tag_e          tag_q;
    tag_e          tag_d;
    logic [BW-1:0] rd_live;
    logic [BW-1:0] i_hold;
    logic [BW-1:0] d_hold;
    logic          i_valid;
    logic          d_valid;

    assign i_oor = addr_oor(bus.i_addr, AW);
    assign d_oor = addr_oor(bus.d_addr, AW);

    toy_starve_ctr #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .d_gnt  (d_win),
        .i_req  (bus.i_req),
        .force_i(force_i)
    );

    always_comb begin
        d_win = 1'b0;
        i_win = 1'b0;
        if (!rst) begin
            if (bus.d_req && !(bus.i_req && force_i)) begin
                d_win = 1'b1;
            end else if (bus.i_req) begin
                i_win = 1'b1;
            end
        end
    end

    // Out-of-range grants keep the macro deselected but still tag reads
    always_comb begin
        m_csn   = 1'b1;
        m_wen   = 1'b1;
        m_a     = '0;
        m_di    = '0;
        win_oor = 1'b0;
        tag_d   = TAG_NONE;
        if (d_win) begin
            m_a     = bus.d_addr[AW-1:0];
            m_csn   = d_oor;
            win_oor = d_oor;
            if (bus.d_rw == DRW_WRITE) begin
                m_wen = 1'b0;
                m_di  = bus.d_wdata;
            end else begin
                tag_d = TAG_D;
            end
        end else if (i_win) begin
            m_a     = bus.i_addr[AW-1:0];
            m_csn   = i_oor;
            win_oor = i_oor;
            tag_d   = TAG_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= TAG_NONE;
            oor_q    <= 1'b0;
            addr_err <= 1'b0;
            i_hold   <= '0;
            d_hold   <= '0;
        end else begin
            tag_q <= tag_d;
            oor_q <= win_oor;
            if (win_oor) begin
                addr_err <= 1'b1;
            end
            if (i_valid) begin
                i_hold <= rd_live;
            end
            if (d_valid) begin
                d_hold <= rd_live;
            end
        end
    end

    assign rd_live = oor_q ? '0 : m_dout;
    assign i_valid = !rst && (tag_q == TAG_I);
    assign d_valid = !rst && (tag_q == TAG_D);

    assign bus.i_gnt   = i_win;
    assign bus.d_gnt   = d_win;
    assign bus.i_valid = i_valid;
    assign bus.d_valid = d_valid;
    assign bus.i_rdata = i_valid ? rd_live : i_hold;
    assign bus.d_rdata = d_valid ? rd_live : d_hold;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Self-checking bench for toy_mem_arbiter with a behavioural SRAM.
// Directed scenarios plus a randomized run against a reference model.
module tb_toy_mem_arbiter;
    import toy_mem_pkg::*;

    localparam int AW   = 10;
    localparam int BW   = 32;
    localparam int MAXS = 4;
    localparam int N    = 1 << AW;
    localparam int NPRE = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toy_mem_arbiter_if #(.BW(BW)) bus ();

    logic          m_csn;
    logic          m_wen;
    logic [AW-1:0] m_a;
    logic [BW-1:0] m_di;
    logic [BW-1:0] m_dout;
    logic          addr_err;

    toy_mem_arbiter #(
        .AW(AW), .BW(BW), .MAX_DSTREAK(MAXS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .m_csn   (m_csn),
        .m_wen   (m_wen),
        .m_a     (m_a),
        .m_di    (m_di),
        .m_dout  (m_dout),
        .addr_err(addr_err)
    );

    logic [BW-1:0] sram [N];
    logic [BW-1:0] ref_mem [N];
    logic          load_en;
    logic [AW-1:0] load_a;
    logic [BW-1:0] load_d;

    always @(posedge clk) begin
        if (load_en) begin
            sram[load_a] <= load_d;
        end else if (!m_csn) begin
            if (!m_wen) sram[m_a] <= m_di;
            else m_dout <= sram[m_a];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_rw    = DRW_READ;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic preload();
        logic [BW-1:0] v;
        for (int k = 0; k < NPRE; k++) begin
            v = (k < 4) ? BW'(32'hA0 + k) : BW'($urandom);
            ref_mem[k] = v;
            load_en = 1'b1;
            load_a  = AW'(k);
            load_d  = v;
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.d_req  = 1'b1;
        bus.d_addr = 30'h10;
        @(negedge clk);
        n_total++; if (bus.d_gnt !== 1'b0) $display("FAIL rst_dgnt got=%0b exp=0", bus.d_gnt); else n_pass++;
        n_total++; if (bus.i_gnt !== 1'b0) $display("FAIL rst_ignt got=%0b exp=0", bus.i_gnt); else n_pass++;
        n_total++; if (m_csn !== 1'b1) $display("FAIL rst_csn got=%0b exp=1", m_csn); else n_pass++;
        n_total++; if (m_wen !== 1'b1) $display("FAIL rst_wen got=%0b exp=1", m_wen); else n_pass++;
        n_total++; if (m_a !== '0) $display("FAIL rst_ma got=%0h exp=0", m_a); else n_pass++;
        n_total++; if (m_di !== '0) $display("FAIL rst_mdi got=%0h exp=0", m_di); else n_pass++;
        n_total++; if ({bus.i_valid, bus.d_valid} !== 2'b00) $display("FAIL rst_valid got=%b exp=00", {bus.i_valid, bus.d_valid}); else n_pass++;
        n_total++; if (bus.i_rdata !== '0) $display("FAIL rst_irdata got=%0h exp=0", bus.i_rdata); else n_pass++;
        n_total++; if (bus.d_rdata !== '0) $display("FAIL rst_drdata got=%0h exp=0", bus.d_rdata); else n_pass++;
        n_total++; if (addr_err !== 1'b0) $display("FAIL rst_aerr got=%0b exp=0", addr_err); else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.d_gnt !== 1'b1) $display("FAIL mid_dgnt got=%0b exp=1", bus.d_gnt); else n_pass++;
        n_total++; if (m_csn !== 1'b0 || m_a !== AW'(10'h10)) $display("FAIL mid_drive got csn=%0b a=%0h exp csn=0 a=10", m_csn, m_a); else n_pass++;
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (bus.d_valid !== 1'b0) $display("FAIL mid_dvalid got=%0b exp=0", bus.d_valid); else n_pass++;
        n_total++; if (m_csn !== 1'b1) $display("FAIL mid_csn got=%0b exp=1", m_csn); else n_pass++;
        n_total++; if (addr_err !== 1'b0) $display("FAIL mid_aerr got=%0b exp=0", addr_err); else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.d_valid !== 1'b0) $display("FAIL post_dvalid got=%0b exp=0", bus.d_valid); else n_pass++;
        tick();
    endtask

    task automatic test_ifetch();
        for (int k = 0; k < 4; k++) begin
            bus.i_req  = 1'b1;
            bus.i_addr = 30'(k);
            @(negedge clk);
            n_total++; if (bus.i_gnt !== 1'b1) $display("FAIL if_gnt k=%0d got=%0b exp=1", k, bus.i_gnt); else n_pass++;
            n_total++; if (m_a !== AW'(k) || m_csn !== 1'b0) $display("FAIL if_ma k=%0d got=%0h exp=%0h", k, m_a, k); else n_pass++;
            if (k > 0) begin
                n_total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== BW'(32'hA0 + k - 1)) $display("FAIL if_data k=%0d got v=%0b d=%0h exp v=1 d=%0h", k, bus.i_valid, bus.i_rdata, 32'hA0 + k - 1); else n_pass++;
            end
            tick();
        end
        idle();
        @(negedge clk);
        n_total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== BW'(32'hA3)) $display("FAIL if_last got v=%0b d=%0h exp v=1 d=a3", bus.i_valid, bus.i_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_streak();
        string pat = "DDDDIDDDDI";
        bus.i_req  = 1'b1;
        bus.i_addr = 30'h30;
        bus.d_req  = 1'b1;
        bus.d_rw   = DRW_READ;
        bus.d_addr = 30'h20;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_total++; if ({bus.d_gnt, bus.i_gnt} !== ((pat[c] == "D") ? 2'b10 : 2'b01)) $display("FAIL streak_gnt c=%0d got d=%0b i=%0b exp %s", c, bus.d_gnt, bus.i_gnt, (pat[c] == "D") ? "D" : "I"); else n_pass++;
            if (c > 0 && pat[c-1] == "I") begin
                n_total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== ref_mem[6'h30]) $display("FAIL streak_idata c=%0d got %0h exp %0h", c, bus.i_rdata, ref_mem[6'h30]); else n_pass++;
            end
            if (c > 0 && pat[c-1] == "D") begin
                n_total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== ref_mem[6'h20]) $display("FAIL streak_ddata c=%0d got %0h exp %0h", c, bus.d_rdata, ref_mem[6'h20]); else n_pass++;
            end
            tick();
        end
        idle();
        @(negedge clk);
        n_total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== ref_mem[6'h30]) $display("FAIL streak_ilast got v=%0b d=%0h exp %0h", bus.i_valid, bus.i_rdata, ref_mem[6'h30]); else n_pass++;
        tick();
    endtask

    task automatic test_raw();
        bus.d_req   = 1'b1;
        bus.d_rw    = DRW_WRITE;
        bus.d_addr  = 30'h5;
        bus.d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_total++; if (bus.d_gnt !== 1'b1 || m_wen !== 1'b0 || m_csn !== 1'b0) $display("FAIL raw_wr got gnt=%0b wen=%0b csn=%0b exp 1 0 0", bus.d_gnt, m_wen, m_csn); else n_pass++;
        n_total++; if (m_di !== 32'hDEADBEEF) $display("FAIL raw_mdi got=%0h exp=deadbeef", m_di); else n_pass++;
        tick();
        ref_mem[5] = 32'hDEADBEEF;
        bus.d_rw    = DRW_READ;
        bus.d_wdata = '0;
        @(negedge clk);
        n_total++; if (bus.d_gnt !== 1'b1 || m_wen !== 1'b1) $display("FAIL raw_rd got gnt=%0b wen=%0b exp 1 1", bus.d_gnt, m_wen); else n_pass++;
        n_total++; if (bus.d_valid !== 1'b0) $display("FAIL raw_novalid got=%0b exp=0", bus.d_valid); else n_pass++;
        n_total++; if (m_di !== '0) $display("FAIL raw_mdi0 got=%0h exp=0", m_di); else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) $display("FAIL raw_data got v=%0b d=%0h exp v=1 d=deadbeef", bus.d_valid, bus.d_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_hold();
        bus.i_req  = 1'b1;
        bus.i_addr = 30'h2;
        tick();
        idle();
        bus.d_req  = 1'b1;
        bus.d_addr = 30'h10;
        tick();
        idle();
        @(negedge clk);
        n_total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== ref_mem[16]) $display("FAIL hold_first got v=%0b d=%0h exp %0h", bus.d_valid, bus.d_rdata, ref_mem[16]); else n_pass++;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++; if (bus.d_valid !== 1'b0 || bus.d_rdata !== ref_mem[16]) $display("FAIL hold_d c=%0d got v=%0b d=%0h exp %0h", c, bus.d_valid, bus.d_rdata, ref_mem[16]); else n_pass++;
            n_total++; if (bus.i_valid !== 1'b0 || bus.i_rdata !== BW'(32'hA2)) $display("FAIL hold_i c=%0d got v=%0b d=%0h exp a2", c, bus.i_valid, bus.i_rdata); else n_pass++;
            tick();
        end
    endtask

    // Model: I is owed the slot once it has watched MAXS D grants in a row.
    task automatic test_random();
        int            waited;
        int            pend;
        logic [BW-1:0] pdata;
        logic [BW-1:0] ih;
        logic [BW-1:0] dh;
        logic [BW-1:0] exp_i;
        logic [BW-1:0] exp_d;
        bit            d_won;
        bit            i_won;
        idle();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        waited = 0;
        pend   = 0;
        pdata  = '0;
        ih     = '0;
        dh     = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            i_won = bus.i_req && (!bus.d_req || waited >= MAXS);
            d_won = bus.d_req && !i_won;
            exp_i = (pend == 1) ? pdata : ih;
            exp_d = (pend == 2) ? pdata : dh;
            n_total++; if (bus.d_gnt !== d_won || bus.i_gnt !== i_won) $display("FAIL rnd_gnt c=%0d got d=%0b i=%0b exp d=%0b i=%0b", c, bus.d_gnt, bus.i_gnt, d_won, i_won); else n_pass++;
            n_total++; if (bus.i_valid !== (pend == 1) || bus.i_rdata !== exp_i) $display("FAIL rnd_i c=%0d got v=%0b d=%0h exp v=%0b d=%0h", c, bus.i_valid, bus.i_rdata, pend == 1, exp_i); else n_pass++;
            n_total++; if (bus.d_valid !== (pend == 2) || bus.d_rdata !== exp_d) $display("FAIL rnd_d c=%0d got v=%0b d=%0h exp v=%0b d=%0h", c, bus.d_valid, bus.d_rdata, pend == 2, exp_d); else n_pass++;
            ih   = exp_i;
            dh   = exp_d;
            pend = 0;
            if (d_won) begin
                if (bus.d_rw == DRW_WRITE) begin
                    ref_mem[bus.d_addr[AW-1:0]] = bus.d_wdata;
                end else begin
                    pend  = 2;
                    pdata = ref_mem[bus.d_addr[AW-1:0]];
                end
            end else if (i_won) begin
                pend  = 1;
                pdata = ref_mem[bus.i_addr[AW-1:0]];
            end
            if (bus.i_req && d_won) waited = (waited < 15) ? waited + 1 : 15;
            else waited = 0;
            tick();
            if (bus.d_req && !d_won) begin
                if ($urandom_range(9) == 0) bus.d_req = 1'b0;
            end else begin
                bus.d_req   = ($urandom_range(3) != 0);
                bus.d_rw    = 1'($urandom_range(1));
                bus.d_addr  = 30'($urandom_range(NPRE - 1));
                bus.d_wdata = BW'($urandom);
            end
            if (bus.i_req && !i_won) begin
                if ($urandom_range(9) == 0) bus.i_req = 1'b0;
            end else begin
                bus.i_req  = ($urandom_range(3) != 0);
                bus.i_addr = 30'($urandom_range(NPRE - 1));
            end
        end
        idle();
        tick();
    endtask

    task automatic test_oor();
        tick();
        bus.d_req  = 1'b1;
        bus.d_rw   = DRW_READ;
        bus.d_addr = 30'h400;
        @(negedge clk);
        n_total++; if (bus.d_gnt !== 1'b1 || m_csn !== 1'b1) $display("FAIL oor_gnt got gnt=%0b csn=%0b exp 1 1", bus.d_gnt, m_csn); else n_pass++;
        n_total++; if (addr_err !== 1'b0) $display("FAIL oor_early got=%0b exp=0", addr_err); else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== '0) $display("FAIL oor_data got v=%0b d=%0h exp v=1 d=0", bus.d_valid, bus.d_rdata); else n_pass++;
        n_total++; if (addr_err !== 1'b1) $display("FAIL oor_aerr got=%0b exp=1", addr_err); else n_pass++;
        for (int c = 0; c < 3; c++) tick();
        @(negedge clk);
        n_total++; if (addr_err !== 1'b1) $display("FAIL oor_sticky got=%0b exp=1", addr_err); else n_pass++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (addr_err !== 1'b0) $display("FAIL oor_clear got=%0b exp=0", addr_err); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        load_en = 1'b0;
        load_a  = '0;
        load_d  = '0;
        idle();
        preload();
        test_reset();
        test_ifetch();
        test_streak();
        test_raw();
        test_hold();
        test_random();
        test_oor();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
